// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write-port bundle for imem_loader.
//   rx_valid / rx_data / rx_ready : host byte link (valid/ready handshake)
//   imem_we / imem_addr / imem_wdata : instruction memory write port
// The slave modport is the loader side; the master modport is the host/memory side.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader.
// Receives a 4-byte little-endian length header followed by that many little-endian
// 32-bit words, and writes each word to the instruction memory while holding the CPU.
// Ports:
//   i_clk, i_reset    : clock, synchronous active-high reset
//   i_start           : one-cycle load request (honoured in IDLE, DONE, ERROR)
//   io_bus            : byte link in, instruction memory write port out
//   o_cpu_hold        : stall request to the core
//   o_busy            : high in LEN, DATA, WRITE
//   o_done / o_error  : level status of the last load
//   o_words_written   : words committed in the current or last load
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  imem_loader_if.slave      io_bus,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [31:0]       o_words_written
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e      r_state;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_word_buf;
  logic [31:0] r_length;
  logic [31:0] r_words_written;
  logic        r_rx_ready;
  logic        r_imem_we;
  logic [31:0] r_imem_addr;
  logic [31:0] r_imem_wdata;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_xfer;
  logic        w_last_byte;
  logic [31:0] w_word;
  logic [31:0] w_wr_count;

  assign w_xfer      = io_bus.rx_valid & r_rx_ready;
  assign w_last_byte = w_xfer & (r_byte_cnt == 2'd3);
  assign w_wr_count  = r_words_written + 32'd1;

  // Word buffer with the byte arriving this cycle merged in, so the 4th byte is
  // usable at the same edge it is accepted.
  always_comb begin
    w_word = r_word_buf;
    w_word[{r_byte_cnt, 3'b000} +: 8] = io_bus.rx_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= StIdle;
      r_byte_cnt      <= 2'd0;
      r_word_buf      <= 32'd0;
      r_length        <= 32'd0;
      r_words_written <= 32'd0;
      r_rx_ready      <= 1'b0;
      r_imem_we       <= 1'b0;
      r_imem_addr     <= 32'd0;
      r_imem_wdata    <= 32'd0;
      r_cpu_hold      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      if (w_xfer) begin
        r_word_buf <= w_word;
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end

      unique case (r_state)
        StIdle, StDone, StError: begin
          if (i_start) begin
            r_state         <= StLen;
            r_byte_cnt      <= 2'd0;
            r_word_buf      <= 32'd0;
            r_words_written <= 32'd0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_cpu_hold      <= 1'b1;
            r_busy          <= 1'b1;
            r_rx_ready      <= 1'b1;
          end
        end
        StLen: begin
          if (w_last_byte) begin
            r_length <= w_word;
            if (w_word == 32'd0) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
            end else if (w_word > 32'(DEPTH_WORDS)) begin
              // cpu_hold stays asserted so the core never runs a partial image
              r_state    <= StError;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
              r_rx_ready <= 1'b0;
            end else begin
              r_state <= StData;
            end
          end
        end
        StData: begin
          if (w_last_byte) begin
            r_state      <= StWrite;
            r_rx_ready   <= 1'b0;
            r_imem_we    <= 1'b1;
            r_imem_addr  <= BASE_ADDR + {r_words_written[29:0], 2'b00};
            r_imem_wdata <= w_word;
          end
        end
        StWrite: begin
          r_words_written <= w_wr_count;
          if (w_wr_count == r_length) begin
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
          end else begin
            r_state    <= StData;
            r_rx_ready <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.rx_ready   = r_rx_ready;
  assign io_bus.imem_we    = r_imem_we;
  assign io_bus.imem_addr  = r_imem_addr;
  assign io_bus.imem_wdata = r_imem_wdata;
  assign o_cpu_hold        = r_cpu_hold;
  assign o_busy            = r_busy;
  assign o_done            = r_done;
  assign o_error           = r_error;
  assign o_words_written   = r_words_written;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives the byte link at the falling edge,
// samples outputs at the falling edge, and logs every memory write pulse.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [31:0] words_written;

  int checks = 0;
  int failures = 0;
  int bytes_sent = 0;

  logic [7:0]  img [0:15];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_bytes [$];

  imem_loader_if bus ();

  imem_loader dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_start         (start),
    .io_bus          (bus),
    .o_cpu_hold      (cpu_hold),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_words_written (words_written)
  );

  always #5 clk = ~clk;

  // Write log: one entry per cycle with imem_we high, tagged with bytes accepted so far.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_wdata);
      wr_bytes.push_back(bytes_sent);
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_bytes.delete();
    bytes_sent = 0;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (bus.rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL byte_accept timeout byte=%h rx_ready=%b required=1", b, bus.rx_ready);
    end else begin
      @(posedge clk);
      bytes_sent++;
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_bytes(input int first, input int n, input int gap);
    for (int i = first; i < first + n; i++) send_byte(img[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(output bit seen);
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (done === 1'b1 || error === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic load_two_image();
    img[0] = 8'h02; img[1] = 8'h00; img[2]  = 8'h00; img[3]  = 8'h00;
    img[4] = 8'h13; img[5] = 8'h05; img[6]  = 8'h10; img[7]  = 8'h00;
    img[8] = 8'h93; img[9] = 8'h05; img[10] = 8'h20; img[11] = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.imem_we, cpu_hold, busy, done, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b required=000000",
               {bus.rx_ready, bus.imem_we, cpu_hold, busy, done, error});
    end
    checks++;
    if ({bus.imem_addr, bus.imem_wdata, words_written} !== 96'd0) begin
      failures++;
      $display("FAIL reset_values addr=%h wdata=%h ww=%0d required all 0",
               bus.imem_addr, bus.imem_wdata, words_written);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rx_ready !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL idle_outputs rx_ready=%b cpu_hold=%b required 0 0", bus.rx_ready, cpu_hold);
    end
  endtask

  task automatic check_two_writes(input string tag);
    checks++;
    if (wr_addr.size() != 2) begin
      failures++;
      $display("FAIL %s write_count got=%0d required=2", tag, wr_addr.size());
    end else begin
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0010_0513) begin
        failures++;
        $display("FAIL %s write0 addr=%h data=%h required 00000000 00100513",
                 tag, wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0020_0593) begin
        failures++;
        $display("FAIL %s write1 addr=%h data=%h required 00000004 00200593",
                 tag, wr_addr[1], wr_data[1]);
      end
      checks++;
      if (wr_bytes[0] != 8 || wr_bytes[1] != 12) begin
        failures++;
        $display("FAIL %s write_timing bytes_at_we=%0d,%0d required 8,12",
                 tag, wr_bytes[0], wr_bytes[1]);
      end
    end
  endtask

  task automatic test_load_two();
    bit seen;
    clear_log();
    load_two_image();
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || busy !== 1'b1 || bus.rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL len_entry hold=%b busy=%b rx_ready=%b required 1 1 1",
               cpu_hold, busy, bus.rx_ready);
    end
    send_bytes(0, 12, 0);
    // Last byte just accepted: WRITE cycle, still held, not done.
    checks++;
    if (bus.imem_we !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || bus.rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL final_write we=%b hold=%b done=%b rx_ready=%b required 1 1 0 0",
               bus.imem_we, cpu_hold, done, bus.rx_ready);
    end
    wait_end(seen);
    checks++;
    if (!seen || done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL load_two_done done=%b hold=%b busy=%b required 1 0 0", done, cpu_hold, busy);
    end
    checks++;
    if (words_written !== 32'd2) begin
      failures++;
      $display("FAIL load_two_count got=%0d required=2", words_written);
    end
    check_two_writes("load_two");
    checks++;
    if (bus.imem_addr !== 32'h4 || bus.imem_wdata !== 32'h0020_0593) begin
      failures++;
      $display("FAIL hold_last addr=%h data=%h required 00000004 00200593",
               bus.imem_addr, bus.imem_wdata);
    end
  endtask

  task automatic test_stalled();
    bit seen;
    clear_log();
    load_two_image();
    pulse_start();
    send_bytes(0, 12, 3);
    wait_end(seen);
    checks++;
    if (!seen || done !== 1'b1 || words_written !== 32'd2) begin
      failures++;
      $display("FAIL stalled_done done=%b ww=%0d required 1 2", done, words_written);
    end
    check_two_writes("stalled");
  endtask

  task automatic test_len_zero();
    bit seen;
    clear_log();
    img[0] = 8'h00; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    pulse_start();
    send_bytes(0, 4, 0);
    wait_end(seen);
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL len_zero_done done=%b error=%b hold=%b required 1 0 0", done, error, cpu_hold);
    end
    checks++;
    if (wr_addr.size() != 0 || words_written !== 32'd0) begin
      failures++;
      $display("FAIL len_zero_writes writes=%0d ww=%0d required 0 0", wr_addr.size(), words_written);
    end
  endtask

  task automatic test_oversize();
    bit seen;
    clear_log();
    img[0] = 8'h01; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h00;
    pulse_start();
    send_bytes(0, 4, 0);
    wait_end(seen);
    repeat (3) @(negedge clk);
    checks++;
    if (!seen || error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b0
        || bus.rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL oversize_error error=%b hold=%b done=%b busy=%b rx_ready=%b required 1 1 0 0 0",
               error, cpu_hold, done, busy, bus.rx_ready);
    end
    checks++;
    if (wr_addr.size() != 0) begin
      failures++;
      $display("FAIL oversize_writes got=%0d required=0", wr_addr.size());
    end
    // Recovery with a one-word image.
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'hEF; img[5] = 8'hBE; img[6] = 8'hAD; img[7] = 8'hDE;
    pulse_start();
    send_bytes(0, 8, 0);
    wait_end(seen);
    checks++;
    if (!seen || done !== 1'b1 || error !== 1'b0 || words_written !== 32'd1) begin
      failures++;
      $display("FAIL recover_done done=%b error=%b ww=%0d required 1 0 1", done, error, words_written);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL recover_write writes=%0d required 1 at 00000000 data deadbeef", wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_word();
    bit seen;
    clear_log();
    img[0] = 8'h03; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h13; img[5] = 8'h05; img[6] = 8'h10; img[7] = 8'h00;
    img[8] = 8'h93; img[9] = 8'h05;
    pulse_start();
    send_bytes(0, 10, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.rx_ready, bus.imem_we, cpu_hold, busy, done, error} !== 6'b0
        || {bus.imem_addr, bus.imem_wdata, words_written} !== 96'd0) begin
      failures++;
      $display("FAIL midreset_outputs flags=%b addr=%h wdata=%h ww=%0d required all 0",
               {bus.rx_ready, bus.imem_we, cpu_hold, busy, done, error},
               bus.imem_addr, bus.imem_wdata, words_written);
    end
    reset = 1'b0;
    // Offer the remaining bytes; an idle loader must not take them or write.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h20;
    repeat (6) @(negedge clk);
    bus.rx_valid = 1'b0;
    checks++;
    if (wr_addr.size() != 1 || bus.rx_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle writes=%0d rx_ready=%b busy=%b required 1 0 0",
               wr_addr.size(), bus.rx_ready, busy);
    end
    clear_log();
    img[0] = 8'h01; img[1] = 8'h00; img[2] = 8'h00; img[3] = 8'h00;
    img[4] = 8'h78; img[5] = 8'h56; img[6] = 8'h34; img[7] = 8'h12;
    pulse_start();
    send_bytes(0, 8, 0);
    wait_end(seen);
    checks++;
    if (!seen || wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL after_reset_load writes=%0d required 1 at 00000000 data 12345678",
               wr_addr.size());
    end
  endtask

  task automatic test_start_busy();
    bit seen;
    clear_log();
    load_two_image();
    pulse_start();
    send_bytes(0, 10, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_mid_data got=%b required=1", busy);
    end
    pulse_start();
    send_bytes(10, 2, 0);
    wait_end(seen);
    checks++;
    if (!seen || done !== 1'b1 || words_written !== 32'd2) begin
      failures++;
      $display("FAIL start_busy_done done=%b ww=%0d required 1 2", done, words_written);
    end
    check_two_writes("start_busy");
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_load_two();
    test_stalled();
    test_len_zero();
    test_oversize();
    test_reset_mid_word();
    test_start_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name:
imem_loader

Overview:
- Boot-time programming controller for the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Drives the instruction memory write port (write_enable / write_addr / write_data) one word at a time.
- Holds the CPU in stall while an image is loading. Sits between the host byte link and the instruction memory write port.

Parameters:
- DEPTH_WORDS, 256: instruction memory capacity in 32-bit words; a length header above this is rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first loaded word; must be 4-byte aligned.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR.
- rx_valid  input  1  byte-stream valid.
- rx_data  input  8  byte-stream data.
- rx_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable.
- imem_addr  output  32  byte address of the word being written; always 4-byte aligned.
- imem_wdata  output  32  assembled instruction word.
- cpu_hold  output  1  stall/hold request to the core.
- busy  output  1  high in LEN, DATA and WRITE.
- done  output  1  level; image fully written.
- error  output  1  level; length header rejected.
- words_written  output  32  count of words committed in the current or last load.

Behaviour:
- Reset (synchronous, active-high):
  - Controller returns to IDLE.
  - rx_ready, imem_we, cpu_hold, busy, done, error = 0.
  - imem_addr, imem_wdata, words_written = 0.
  - Byte counter, length register and word buffer are cleared.
- Reset mid-load: takes effect at the same edge. Any partial word is discarded and no further imem_we is issued. Words already written stay in memory.
- Handshake: a byte transfers on the clk edge where rx_valid && rx_ready. A 2-bit byte counter places byte k into bits [8k+7:8k], so the first byte received is the LSB.
- IDLE:
  - rx_ready=0, cpu_hold=0.
  - start -> LEN. Clear done, error, words_written and the byte counter; set cpu_hold=1.
- LEN:
  - rx_ready=1, cpu_hold=1.
  - After the 4th byte, the length register is loaded and the next state is chosen:
    - length == 0 -> DONE.
    - length > DEPTH_WORDS -> ERROR.
    - otherwise -> DATA.
- DATA:
  - rx_ready=1.
  - After the 4th byte, the word buffer is complete -> WRITE.
  - rx_ready is 0 from the following cycle onward.
- WRITE:
  - Lasts exactly one cycle, with rx_ready=0 and imem_we=1.
  - imem_addr = BASE_ADDR + 4*words_written (32-bit, wraps modulo 2^32).
  - imem_wdata = word buffer.
  - At the edge, words_written increments.
  - If the new words_written == length -> DONE, else -> DATA.
- DONE:
  - done=1, cpu_hold=0, busy=0, rx_ready=0.
  - Stays here until start, which re-enters LEN and clears done.
- ERROR:
  - error=1, rx_ready=0, and cpu_hold stays 1 so the core never runs an unloaded image.
  - Exits only on start (-> LEN) or reset.
- Timing and output holding:
  - Minimum per word is 4 accepted bytes + 1 write cycle = 5 cycles.
  - imem_addr and imem_wdata keep their last written values outside WRITE.
- start while busy is ignored. Bytes offered while rx_ready=0 are not consumed; the source must hold them.
- rx_valid gaps of any length are legal. The byte counter holds until the next accepted byte.
- Simultaneous reset and start: reset wins.

Test Plan:
- Load 2 words:
  - Stimulus: start, then bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 with rx_valid held high.
  - Required response:
    - imem_we pulses at addr 0x0 with data 0x00100513, then at addr 0x4 with data 0x00200593.
    - done=1, words_written=2, cpu_hold drops on the cycle done rises.
- Stalled source: same image with rx_valid low for 3 cycles between every byte -> identical writes; imem_we never asserts before the 4th byte of each word.
- Length zero: start, then bytes 00 00 00 00 -> DONE with no imem_we pulse and words_written=0.
- Oversize length:
  - Stimulus: DEPTH_WORDS=256, header 01 01 00 00 (257).
  - Required response: error=1, cpu_hold=1, no writes. A subsequent start followed by a valid 1-word image gives done=1 and error=0.
- Reset mid-word: after header 03 00 00 00, one full word, then 2 bytes of the second word, assert reset.
  - Required response: all outputs 0 next cycle, no second imem_we, state IDLE.
  - A later load writes words starting at BASE_ADDR.
- start ignored while busy: pulse start in the middle of DATA -> load continues unchanged; words_written and the addresses are unaffected.
